// File: rtl/div_seq_pkg.sv
// rtl/div_seq_pkg.sv - shared state encoding and constants for the divide sequencer
package div_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT,
        ST_FIX,
        ST_WRITE
    } state_t;

    localparam int MAX_WIDTH = 64;
    localparam logic [MAX_WIDTH-1:0] DBZ_QUOTIENT = '1;

endpackage

// File: rtl/div_sign_fix.sv
// rtl/div_sign_fix.sv - operand magnitudes and result sign correction for signed divide
module div_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic             i_is_signed,
    input  logic [WIDTH-1:0] i_op_a,
    input  logic [WIDTH-1:0] i_op_b,
    output logic             o_sign_a,
    output logic             o_sign_b,
    output logic [WIDTH-1:0] o_mag_a,
    output logic [WIDTH-1:0] o_mag_b,
    input  logic             i_neg_q,
    input  logic             i_neg_r,
    input  logic [WIDTH-1:0] i_q,
    input  logic [WIDTH-1:0] i_r,
    output logic [WIDTH-1:0] o_q,
    output logic [WIDTH-1:0] o_r
);

    assign o_sign_a = i_is_signed & i_op_a[WIDTH-1];
    assign o_sign_b = i_is_signed & i_op_b[WIDTH-1];
    // The most negative value maps onto itself, which the unsigned divider reads correctly.
    assign o_mag_a  = o_sign_a ? -i_op_a : i_op_a;
    assign o_mag_b  = o_sign_b ? -i_op_b : i_op_b;
    assign o_q      = i_neg_q ? -i_q : i_q;
    assign o_r      = i_neg_r ? -i_r : i_r;

endmodule

// File: rtl/div_sequencer.sv
// rtl/div_sequencer.sv - sequences DIV/DIVU through an external unsigned divider into HI/LO
module div_sequencer
    import div_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             flush,
    output logic             divu_start,
    output logic [WIDTH-1:0] divu_dividend,
    output logic [WIDTH-1:0] divu_divisor,
    input  logic             divu_busy,
    input  logic [WIDTH-1:0] divu_q,
    input  logic [WIDTH-1:0] divu_r,
    output logic             stall,
    output logic             hi_we,
    output logic             lo_we,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             done,
    output logic             dbz
);

    state_t           r_state;
    logic             r_start;
    logic             r_we;
    logic             r_dbz;
    logic             r_sign_a;
    logic             r_sign_b;
    logic [WIDTH-1:0] r_mag_a;
    logic [WIDTH-1:0] r_mag_b;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic             w_sign_a;
    logic             w_sign_b;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic [WIDTH-1:0] w_q_fixed;
    logic [WIDTH-1:0] w_r_fixed;
    logic             w_b_zero;

    assign w_b_zero = (op_b == '0);

    div_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
        .i_is_signed (is_signed),
        .i_op_a      (op_a),
        .i_op_b      (op_b),
        .o_sign_a    (w_sign_a),
        .o_sign_b    (w_sign_b),
        .o_mag_a     (w_mag_a),
        .o_mag_b     (w_mag_b),
        .i_neg_q     (r_sign_a ^ r_sign_b),
        .i_neg_r     (r_sign_a),
        .i_q         (divu_q),
        .i_r         (divu_r),
        .o_q         (w_q_fixed),
        .o_r         (w_r_fixed)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_start  <= 1'b0;
            r_we     <= 1'b0;
            r_dbz    <= 1'b0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_mag_a  <= '0;
            r_mag_b  <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_start <= 1'b0;
            r_we    <= 1'b0;
            r_dbz   <= 1'b0;
            if (flush) begin
                r_state <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (req && w_b_zero) begin
                            r_state <= ST_WRITE;
                            r_we    <= 1'b1;
                            r_dbz   <= 1'b1;
                            r_lo    <= DBZ_QUOTIENT[WIDTH-1:0];
                            r_hi    <= op_a;
                        end else if (req) begin
                            r_state  <= ST_LAUNCH;
                            r_start  <= 1'b1;
                            r_sign_a <= w_sign_a;
                            r_sign_b <= w_sign_b;
                            r_mag_a  <= w_mag_a;
                            r_mag_b  <= w_mag_b;
                        end
                    end
                    ST_LAUNCH: r_state <= ST_WAIT;
                    ST_WAIT: begin
                        if (!divu_busy) begin
                            r_state <= ST_FIX;
                        end
                    end
                    ST_FIX: begin
                        r_state <= ST_WRITE;
                        r_we    <= 1'b1;
                        r_lo    <= w_q_fixed;
                        r_hi    <= w_r_fixed;
                    end
                    ST_WRITE: r_state <= ST_IDLE;
                    default:  r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign divu_start    = r_start;
    assign divu_dividend = r_mag_a;
    assign divu_divisor  = r_mag_b;
    assign hi_we         = r_we;
    assign lo_we         = r_we;
    assign done          = r_we;
    assign dbz           = r_dbz;
    assign hi_out        = r_hi;
    assign lo_out        = r_lo;
    assign stall         = req | (r_state != ST_IDLE);

endmodule

// File: tb/tb_div_sequencer.sv
// tb/tb_div_sequencer.sv - directed vector bench for div_sequencer with a 32-cycle divider model
module tb_div_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic        is_signed = 1'b0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        flush = 1'b0;
    logic        divu_start;
    logic [31:0] divu_dividend;
    logic [31:0] divu_divisor;
    logic        divu_busy;
    logic [31:0] divu_q;
    logic [31:0] divu_r;
    logic        stall;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic        done;
    logic        dbz;

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;
    int done_cnt = 0;
    int cnt = 0;

    always #5 clock = ~clock;

    div_sequencer #(.WIDTH(32)) dut (
        .clock         (clock),
        .reset         (reset),
        .req           (req),
        .is_signed     (is_signed),
        .op_a          (op_a),
        .op_b          (op_b),
        .flush         (flush),
        .divu_start    (divu_start),
        .divu_dividend (divu_dividend),
        .divu_divisor  (divu_divisor),
        .divu_busy     (divu_busy),
        .divu_q        (divu_q),
        .divu_r        (divu_r),
        .stall         (stall),
        .hi_we         (hi_we),
        .lo_we         (lo_we),
        .hi_out        (hi_out),
        .lo_out        (lo_out),
        .done          (done),
        .dbz           (dbz)
    );

    // Divider model: busy for 32 cycles after start; a new start restarts it.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt    <= 0;
            divu_q <= '0;
            divu_r <= '0;
        end else if (divu_start) begin
            cnt    <= 32;
            divu_q <= (divu_divisor == 0) ? 32'hFFFF_FFFF : divu_dividend / divu_divisor;
            divu_r <= (divu_divisor == 0) ? divu_dividend : divu_dividend % divu_divisor;
        end else if (cnt != 0) begin
            cnt <= cnt - 1;
        end
    end
    assign divu_busy = (cnt != 0);

    always @(posedge clock) begin
        if (divu_start) start_cnt <= start_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    typedef struct {
        logic        s;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] lo;
        logic [31:0] hi;
        logic        dbz;
        int          lat;
        int          starts;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Issues one request and waits (bounded) for done; lat = -1 on timeout.
    task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b, output int lat);
        req = 1'b1; is_signed = s; op_a = a; op_b = b;
        #1;
        chk("stall_on_req", {31'd0, stall}, 32'd1);
        tick();
        req = 1'b0; op_a = 32'hDEAD_BEEF; op_b = 32'h0;
        lat = -1;
        for (int k = 1; k <= 60; k++) begin
            if (done) begin
                lat = k;
                break;
            end
            tick();
        end
    endtask

    int lat;
    int s0;
    int d0;

    initial begin
        vecs[0] = '{1'b0, 32'd100,        32'd7,        32'd14,        32'd2,         1'b0, 36, 1};
        vecs[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 36, 1};
        vecs[2] = '{1'b1, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,         1'b0, 36, 1};
        vecs[3] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         1'b0, 36, 1};
        vecs[4] = '{1'b0, 32'd5,          32'd0,        32'hFFFF_FFFF, 32'd5,         1'b1, 1,  0};
        vecs[5] = '{1'b0, 32'hFFFF_FFFF,  32'd2,        32'h7FFF_FFFF, 32'd1,         1'b0, 36, 1};
        vecs[6] = '{1'b1, 32'hFFFF_FFF8,  32'hFFFF_FFFD, 32'd2,         32'hFFFF_FFFE, 1'b0, 36, 1};
        vecs[7] = '{1'b1, 32'hFFFF_FFF9,  32'd0,        32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1, 1,  0};

        tick();
        tick();
        chk("rst_done",  {31'd0, done}, 32'd0);
        chk("rst_we",    {30'd0, hi_we, lo_we}, 32'd0);
        chk("rst_start", {31'd0, divu_start}, 32'd0);
        chk("rst_dbz",   {31'd0, dbz}, 32'd0);
        chk("rst_hi",    hi_out, 32'd0);
        chk("rst_lo",    lo_out, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) begin
            s0 = start_cnt;
            run_op(vecs[i].s, vecs[i].a, vecs[i].b, lat);
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            chk($sformatf("v%0d_lo", i), lo_out, vecs[i].lo);
            chk($sformatf("v%0d_hi", i), hi_out, vecs[i].hi);
            chk($sformatf("v%0d_dbz", i), {31'd0, dbz}, {31'd0, vecs[i].dbz});
            chk($sformatf("v%0d_we", i), {30'd0, hi_we, lo_we}, 32'd3);
            chk($sformatf("v%0d_stall", i), {31'd0, stall}, 32'd1);
            chk($sformatf("v%0d_starts", i), 32'(start_cnt - s0), 32'(vecs[i].starts));
            tick();
            chk($sformatf("v%0d_done_pulse", i), {31'd0, done}, 32'd0);
            chk($sformatf("v%0d_dbz_clr", i), {31'd0, dbz}, 32'd0);
            tick();
        end

        // Outputs hold between operations.
        repeat (5) tick();
        chk("hold_lo", lo_out, 32'hFFFF_FFFF);
        chk("hold_hi", hi_out, 32'hFFFF_FFF9);

        // req during WAIT is ignored.
        req = 1'b1; is_signed = 1'b0; op_a = 32'd100; op_b = 32'd7;
        tick();
        req = 1'b0;
        repeat (4) tick();
        req = 1'b1; op_a = 32'd1000; op_b = 32'd10;
        tick();
        req = 1'b0;
        lat = -1;
        for (int k = 6; k <= 60; k++) begin
            if (done) begin
                lat = k;
                break;
            end
            tick();
        end
        chk("ign_latency", 32'(lat), 32'd36);
        chk("ign_lo", lo_out, 32'd14);
        chk("ign_hi", hi_out, 32'd2);
        repeat (2) tick();

        // Flush in WAIT, then a new DIVU 9/3 on the next cycle.
        d0 = done_cnt;
        req = 1'b1; is_signed = 1'b0; op_a = 32'd50; op_b = 32'd5;
        tick();
        req = 1'b0;
        repeat (10) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_idle_stall", {31'd0, stall}, 32'd0);
        chk("flush_busy_high", {31'd0, divu_busy}, 32'd1);
        run_op(1'b0, 32'd9, 32'd3, lat);
        chk("flush_latency", 32'(lat), 32'd36);
        chk("flush_lo", lo_out, 32'd3);
        chk("flush_hi", hi_out, 32'd0);
        chk("flush_one_write", 32'(done_cnt - d0), 32'd0);
        tick();
        chk("flush_total_writes", 32'(done_cnt - d0), 32'd1);
        tick();

        // flush beats req in IDLE.
        s0 = start_cnt;
        d0 = done_cnt;
        req = 1'b1; flush = 1'b1; op_a = 32'd8; op_b = 32'd0;
        tick();
        req = 1'b0; flush = 1'b0;
        #1;
        chk("flush_prio_stall", {31'd0, stall}, 32'd0);
        repeat (3) tick();
        chk("flush_prio_done", 32'(done_cnt - d0), 32'd0);
        chk("flush_prio_start", 32'(start_cnt - s0), 32'd0);

        // Reset asserted in WAIT.
        d0 = done_cnt;
        req = 1'b1; is_signed = 1'b0; op_a = 32'd100; op_b = 32'd7;
        tick();
        req = 1'b0;
        repeat (9) tick();
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_hi", hi_out, 32'd0);
        chk("mid_rst_lo", lo_out, 32'd0);
        chk("mid_rst_flags", {27'd0, done, hi_we, lo_we, divu_start, dbz}, 32'd0);
        tick();
        reset = 1'b0;
        #1;
        chk("mid_rst_stall", {31'd0, stall}, 32'd0);
        repeat (40) tick();
        chk("mid_rst_no_write", 32'(done_cnt - d0), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/div_sequencer.md
DIV_SEQUENCER -- requirements
Module: div_sequencer

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand/result width.
REQ-002 SHALL have port: clock  input  1  rising-edge clock.
REQ-003 SHALL have port: reset  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: req  input  1  one-cycle divide request from the execute stage.
REQ-005 SHALL have port: is_signed  input  1  1 = DIV (signed), 0 = DIVU; sampled with req.
REQ-006 SHALL have port: op_a / op_b  input  WIDTH each  dividend / divisor; sampled with req.
REQ-007 SHALL have port: flush  input  1  pipeline flush; abandons the current operation.
REQ-008 SHALL have port: divu_start  output  1  start pulse to the unsigned divider.
REQ-009 SHALL have port: divu_dividend / divu_divisor  output  WIDTH each  operand magnitudes to the divider.
REQ-010 SHALL have port: divu_busy  input  1  divider busy flag.
REQ-011 SHALL have port: divu_q / divu_r  input  WIDTH each  divider quotient / remainder.
REQ-012 SHALL have port: stall  output  1  freeze pipeline.
REQ-013 SHALL have port: hi_we / lo_we  output  1 each  HI/LO write enables.
REQ-014 SHALL have port: hi_out / lo_out  output  WIDTH each  remainder / quotient, registered.
REQ-015 SHALL have port: done  output  1  one-cycle completion pulse.
REQ-016 SHALL have port: dbz  output  1  divide-by-zero flag; valid while done is high.

Function
REQ-017 SHALL implement states IDLE, LAUNCH, WAIT, FIX, WRITE.
REQ-018 SHALL transition IDLE->LAUNCH on req with op_b != 0, capturing op_a, op_b, is_signed, sign_a and sign_b (both signs are 0 when is_signed = 0).
REQ-019 SHALL, in LAUNCH, assert divu_start for exactly one cycle with |op_a| and |op_b| (two's-complement magnitudes when signed, raw otherwise); next state WAIT.
REQ-020 SHALL leave WAIT for FIX on the first WAIT cycle in which divu_busy = 0.
REQ-021 SHALL, in FIX, register lo_out = quotient negated iff sign_a XOR sign_b, and hi_out = remainder negated iff sign_a; next state WRITE.
REQ-022 SHALL, in WRITE, pulse hi_we, lo_we and done for one cycle; next state IDLE.
REQ-023 SHALL handle op_b == 0 by going IDLE->WRITE without starting the divider, with lo_out = all-ones, hi_out = op_a and dbz = 1.
REQ-024 SHALL handle signed 0x80000000 / 0xFFFFFFFF as lo_out = 0x80000000, hi_out = 0, with no flag.
REQ-025 SHALL drive stall = req OR (state != IDLE), combinationally.
REQ-026 SHALL give a latency from req (cycle 0) to done of cycle 36 for a nonzero divisor, and cycle 1 for a zero divisor.
REQ-027 SHALL ignore req outside IDLE.
REQ-028 SHALL make flush return to IDLE at the next edge from any state and suppress hi_we, lo_we and done; flush has priority over req.
REQ-029 SHALL allow a new request after a flush while divu_busy is still high; the fresh divu_start restarts the divider.
REQ-030 SHALL hold hi_out and lo_out between operations.

Reset
REQ-031 SHALL, on reset, set state = IDLE, and divu_start, hi_we, lo_we, done, dbz, hi_out and lo_out all to 0.
REQ-032 SHALL abort any operation when reset asserts mid-operation, with no write pulse.

Structure
REQ-033 SHALL place the state encoding and the DBZ_QUOTIENT (all-ones) constant in shared package div_seq_pkg.
REQ-034 SHALL place magnitude/negate logic in one combinational sub-module div_sign_fix.
REQ-035 SHALL keep the divider outside the block; the parent connects divu_*.

Verification
REQ-036 SHALL cover: DIVU 100/7 -> done at cycle 36, lo_out = 14, hi_out = 2, dbz = 0.
REQ-037 SHALL cover: DIV -7/2 -> lo_out = 0xFFFFFFFD, hi_out = 0xFFFFFFFF; and 7/-2 -> lo_out = 0xFFFFFFFD, hi_out = 1.
REQ-038 SHALL cover: DIV 0x80000000/0xFFFFFFFF -> lo_out = 0x80000000, hi_out = 0.
REQ-039 SHALL cover: divisor 0, op_a = 5 -> done at cycle 1, dbz = 1, lo_out = 0xFFFFFFFF, hi_out = 5, divu_start never asserted.
REQ-040 SHALL cover: flush at cycle 10 of WAIT, then DIVU 9/3 on the next cycle -> no write for the first operation; second yields lo_out = 3, hi_out = 0 at cycle 36 after its req.
REQ-041 SHALL cover: reset asserted in WAIT -> all outputs 0, state IDLE, stall = 0 on the next cycle with req low.
